// File: rtl/rounder_pkg.sv
// Shared types and sizing for the rounder sequencer and its mask unit.
package rounder_pkg;
  localparam int W   = 64;
  localparam int SHW = 13;
  localparam int P   = 53;

  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RUP, RM_RDN} rm_e;
  typedef enum logic [2:0] {IDLE, MASK, ROUND, NORM, DONE} rs_state_e;
endpackage

// File: rtl/round_seq_ctrl_mask.sv
// Low-bit mask generator: v has ones in [sh-1:0]; any sh >= W saturates to all ones.
module mask #(
  parameter int W   = rounder_pkg::W,
  parameter int SHW = rounder_pkg::SHW
) (
  input  logic [SHW-1:0] sh,
  output logic [W-1:0]   v
);
  import rounder_pkg::*;

  logic [W-1:0] one;
  assign one = {{(W-1){1'b0}}, 1'b1};

  // Saturate first so the shift never sees an out-of-range amount.
  always_comb begin
    v = '1;
    if (sh < SHW'(W)) v = (one << sh) - one;
  end
endmodule

// File: rtl/round_seq_ctrl.sv
// Multi-cycle rounding sequencer: mask -> round/sticky -> increment -> optional renormalise.
module round_seq_ctrl #(
  parameter int W   = rounder_pkg::W,
  parameter int SHW = rounder_pkg::SHW,
  parameter int P   = rounder_pkg::P
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_sig,
  input  logic [SHW-1:0] in_sh,
  input  logic           in_sign,
  input  logic [1:0]     in_rm,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sig,
  output logic           out_eadj,
  output logic           out_inex
);
  import rounder_pkg::*;

  rs_state_e      state, nxt;
  logic [W-1:0]   sig_q, v_q, kept_q, v;
  logic [SHW-1:0] sh_q;
  logic           sign_q;
  rm_e            rm_q;
  logic [W:0]     sum_q, sum;
  logic [W-1:0]   rbits;
  logic           r, s, inc, sh_ge_w, sh_gt_w;

  // Mask driven from the latched shift so v is ready to register in MASK.
  mask #(.W(W), .SHW(SHW)) u_mask (.sh(sh_q), .v(v));

  assign sh_ge_w = (sh_q >= SHW'(W));
  assign sh_gt_w = (sh_q >  SHW'(W));

  // Round/sticky/increment from the registered mask and kept bits.
  always_comb begin
    rbits = sig_q >> (sh_q - SHW'(1));
    r     = (sh_q != '0) && !sh_gt_w && rbits[0];
    s     = sh_gt_w ? (|sig_q) : (|(sig_q & (v_q >> 1)));
    case (rm_q)
      RM_RNE:  inc = r & (s | kept_q[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign_q & (r | s);
      default: inc = sign_q & (r | s);
    endcase
    sum = {1'b0, kept_q} + {{W{1'b0}}, inc};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = MASK;
      MASK:    nxt = ROUND;
      ROUND:   nxt = sum[P] ? NORM : DONE;
      NORM:    nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath registers: operand latch, mask/kept capture, rounded result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= '0;
      sh_q     <= '0;
      sign_q   <= 1'b0;
      rm_q     <= RM_RNE;
      v_q      <= '0;
      kept_q   <= '0;
      sum_q    <= '0;
      out_sig  <= '0;
      out_eadj <= 1'b0;
      out_inex <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sig_q  <= in_sig;
          sh_q   <= in_sh;
          sign_q <= in_sign;
          rm_q   <= rm_e'(in_rm);
        end
        MASK: begin
          v_q    <= v;
          kept_q <= sh_ge_w ? '0 : (sig_q >> sh_q);
        end
        ROUND: begin
          sum_q    <= sum;
          out_inex <= r | s;
          if (!sum[P]) begin
            out_sig  <= sum[W-1:0];
            out_eadj <= 1'b0;
          end
        end
        // Carry-out means sum = 2^P, so the shifted-out bit is zero: no re-round.
        NORM: begin
          out_sig  <= sum_q[W:1];
          out_eadj <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_round_seq_ctrl.sv
// Directed + randomized bench for round_seq_ctrl against an arithmetic rounding model.
module tb_round_seq_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, in_sign = 0, out_valid, out_ready = 0;
  logic [63:0] in_sig = '0, out_sig;
  logic [12:0] in_sh = '0;
  logic [1:0]  in_rm = '0;
  logic        out_eadj, out_inex;
  int vectors = 0, miscompares = 0;

  round_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_sh(in_sh), .in_sign(in_sign), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig),
    .out_eadj(out_eadj), .out_inex(out_inex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rounding from first principles: split into kept and discarded value, compare
  // the discarded part against one half ulp, apply the mode, renormalise at 2^53.
  task automatic model(input logic [63:0] sig, input int sh, input bit sign, input int rm,
                       output logic [63:0] o, output bit e, output bit x, output int lat);
    logic [127:0] big, kept, disc, half, sum;
    bit above, tie, nz, up;
    big = {64'd0, sig};
    if (sh == 0) begin kept = big; disc = 0; half = 1; end
    else if (sh <= 64) begin
      kept = big >> sh; disc = big - (kept << sh); half = 128'd1 << (sh - 1);
    end else begin
      kept = 0; disc = big; half = 128'd1 << 100;  // whole value lies far below half
    end
    nz    = (disc != 0);
    tie   = (disc == half);
    above = (disc > half);
    case (rm)
      0: up = above || (tie && kept[0]);
      1: up = 0;
      2: up = !sign && nz;
      default: up = sign && nz;
    endcase
    x   = nz;
    sum = kept + (up ? 128'd1 : 128'd0);
    if (sum[53]) begin o = sum[64:1]; e = 1; lat = 4; end
    else begin o = sum[63:0]; e = 0; lat = 3; end
  endtask

  task automatic run_op(input string tag, input logic [63:0] sig, input int sh, input bit sign,
                        input int rm, input int hold);
    logic [63:0] eo; bit ee, ex; int el, cyc, wt; logic [63:0] snap;
    model(sig, sh, sign, rm, eo, ee, ex, el);
    wt = 0;
    while (!in_ready && wt < 20) begin @(negedge clk); wt++; end
    in_valid = 1; in_sig = sig; in_sh = 13'(sh); in_sign = sign; in_rm = 2'(rm);
    @(posedge clk); @(negedge clk);
    in_valid = 0; in_sig = $urandom;
    chk({tag, ":busy"}, in_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
    chk({tag, ":lat"}, cyc, el);
    chk({tag, ":sig"}, out_sig, eo);
    chk({tag, ":eadj"}, out_eadj, ee);
    chk({tag, ":inex"}, out_inex, ex);
    snap = out_sig;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold"}, {out_valid, in_ready, out_sig}, {1'b1, 1'b0, snap});
    end
    out_ready = 1;
    @(posedge clk); @(negedge clk);
    out_ready = 0;
    chk({tag, ":rel"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst", {in_ready, out_valid, out_sig, out_eadj, out_inex}, {1'b1, 1'b0, 64'd0, 2'b00});
    rst_n = 1;
    @(negedge clk);
    // RNE tie cases
    run_op("rne_t_even", 64'h6, 1, 0, 0, 0);
    run_op("rne_t_odd5", 64'h5, 1, 0, 0, 0);
    run_op("rne_t_odd7", 64'h7, 1, 0, 0, 0);
    chk("rne7_exp", out_sig, 64'h4);
    // directed modes
    run_op("rtz", 64'h9, 2, 0, 1, 0);
    chk("rtz_exp", out_sig, 64'h2);
    run_op("rup_p", 64'h9, 2, 0, 2, 0);
    run_op("rdn_p", 64'h9, 2, 0, 3, 0);
    run_op("rdn_n", 64'h9, 2, 1, 3, 0);
    chk("rdn_n_exp", out_sig, 64'h3);
    // carry / renormalise
    run_op("carry", (64'd1 << 54) - 1, 1, 0, 0, 0);
    chk("carry_exp", {out_eadj, out_sig}, {1'b1, 64'd1 << 52});
    // extremes
    run_op("sh0", 64'h000F_1234_5678_9ABC, 0, 0, 0, 0);
    run_op("sh64", 64'h8000_0000_0000_0001, 64, 0, 0, 0);
    run_op("sh100", 64'h1, 100, 0, 2, 0);
    chk("sh100_exp", {out_inex, out_sig}, {1'b1, 64'd1});
    for (int m = 0; m < 4; m++) run_op("zero", 64'd0, 7, m[0], m, 0);
    // back-pressure
    run_op("hold", 64'h1234_5678, 5, 1, 2, 5);
    // reset mid-flight in ROUND
    in_valid = 1; in_sig = 64'hFF; in_sh = 13'd3; in_rm = 2'd0;
    @(posedge clk); @(negedge clk); in_valid = 0;
    @(posedge clk); @(negedge clk);   // now in ROUND
    rst_n = 0; #1;
    chk("rst_async", {in_ready, out_valid}, 2'b10);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_drop", {in_ready, out_valid}, 2'b10);
    end
    // randomized
    for (int n = 0; n < 60; n++) begin
      logic [63:0] sg; int sh;
      sg = {$urandom, $urandom};
      if (n % 3 == 0) sg = sg & ((64'd1 << $urandom_range(1, 63)) - 1);
      sh = (n % 7 == 0) ? $urandom_range(60, 200) : $urandom_range(0, 66);
      run_op("rand", sg, sh, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
